// File: rtl/ramp_ctrl.sv
// ramp_ctrl: soft-start ramp of interrupter frequency and pulse width,
// with overcurrent cooldown and lockout after repeated trips.
module ramp_ctrl #(
   parameter int CLK_MHZ     = 100,
   parameter int STEP_US     = 1000,
   parameter int PAR_MAX_VAL = 255,
   parameter int FAULT_MAX   = 4,
   parameter int COOL_STEPS  = 100,
   localparam int W = $clog2(PAR_MAX_VAL + 1)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic [W-1:0] freq_tgt,
   input  logic [W-1:0] pw_tgt,
   input  logic         ocd,
   output logic [W-1:0] freq_par,
   output logic [W-1:0] pw_par,
   output logic         run,
   output logic         fault,
   output logic [2:0]   state
);

   localparam int STEP_CYC = CLK_MHZ * STEP_US;
   localparam int PW = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;
   localparam int FW = (FAULT_MAX > 0) ? $clog2(FAULT_MAX + 1) : 1;
   localparam int CW = (COOL_STEPS > 0) ? $clog2(COOL_STEPS + 1) : 1;

   localparam logic [PW-1:0] PRE_LAST = PW'(STEP_CYC - 1);
   localparam logic [FW-1:0] F_MAX    = FW'(FAULT_MAX);
   localparam logic [CW-1:0] C_MAX    = CW'(COOL_STEPS);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RAMP = 3'd1,
      HOLD = 3'd2,
      COOL = 3'd3,
      LOCK = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic [W-1:0]  pw_q, pw_d;
   logic [W-1:0]  freq_q, freq_d;
   logic          run_q, run_d;
   logic          fault_q, fault_d;
   logic          ocd_q;
   logic [FW-1:0] fcnt_q, fcnt_d;
   logic [PW-1:0] pre_q, pre_d;
   logic [CW-1:0] cool_q, cool_d;

   logic          tick;
   logic          ocd_edge;
   logic          at_tgt;
   logic [W-1:0]  pw_step;
   logic [W-1:0]  freq_step;
   logic [FW-1:0] fcnt_inc;
   logic [CW-1:0] cool_nx;

   // One unit toward the target; never moves past it, so never wraps.
   function automatic logic [W-1:0] step_to(
      input logic [W-1:0] cur,
      input logic [W-1:0] tgt
   );
      logic [W-1:0] r;
      r = cur;
      if (cur < tgt) begin
         r = cur + W'(1);
      end else if (cur > tgt) begin
         r = cur - W'(1);
      end
      return r;
   endfunction

   assign tick      = (pre_q == PRE_LAST);
   assign ocd_edge  = ocd & ~ocd_q;
   assign at_tgt    = (pw_q == pw_tgt) && (freq_q == freq_tgt);
   assign pw_step   = step_to(pw_q, pw_tgt);
   assign freq_step = step_to(freq_q, freq_tgt);
   assign fcnt_inc  = (fcnt_q == F_MAX) ? fcnt_q : fcnt_q + FW'(1);
   assign cool_nx   = cool_q + CW'(1);

   always_comb begin
      state_d = state_q;
      pw_d    = pw_q;
      freq_d  = freq_q;
      fcnt_d  = fcnt_q;
      cool_d  = cool_q;
      pre_d   = tick ? '0 : pre_q + PW'(1);

      unique case (state_q)
         IDLE: begin
            pw_d   = '0;
            freq_d = freq_tgt;
            fcnt_d = '0;
            cool_d = '0;
            if (en) begin
               state_d = RAMP;
               pre_d   = '0;
            end
         end
         RAMP, HOLD: begin
            // ocd trip outranks en drop, which outranks stepping
            if (ocd_edge) begin
               pw_d    = '0;
               fcnt_d  = fcnt_inc;
               cool_d  = '0;
               pre_d   = '0;
               state_d = (fcnt_inc == F_MAX) ? LOCK : COOL;
            end else if (!en) begin
               pw_d    = '0;
               state_d = IDLE;
            end else if (state_q == RAMP) begin
               if (at_tgt) begin
                  state_d = HOLD;
               end else if (tick) begin
                  pw_d   = pw_step;
                  freq_d = freq_step;
               end
            end else if (!at_tgt) begin
               state_d = RAMP;
               pre_d   = '0;
            end
         end
         COOL: begin
            pw_d = '0;
            if (tick) begin
               cool_d = cool_nx;
               if (cool_nx == C_MAX) begin
                  cool_d  = '0;
                  state_d = en ? RAMP : IDLE;
               end
            end
         end
         LOCK: begin
            pw_d = '0;
            if (!en) begin
               fcnt_d  = '0;
               state_d = IDLE;
            end
         end
         default: begin
            pw_d    = '0;
            state_d = IDLE;
         end
      endcase

      run_d   = (state_d == RAMP) || (state_d == HOLD);
      fault_d = (state_d == LOCK);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         pw_q    <= '0;
         freq_q  <= '0;
         run_q   <= 1'b0;
         fault_q <= 1'b0;
         ocd_q   <= 1'b0;
         fcnt_q  <= '0;
         pre_q   <= '0;
         cool_q  <= '0;
      end else begin
         state_q <= state_d;
         pw_q    <= pw_d;
         freq_q  <= freq_d;
         run_q   <= run_d;
         fault_q <= fault_d;
         ocd_q   <= ocd;
         fcnt_q  <= fcnt_d;
         pre_q   <= pre_d;
         cool_q  <= cool_d;
      end
   end

   assign pw_par   = pw_q;
   assign freq_par = freq_q;
   assign run      = run_q;
   assign fault    = fault_q;
   assign state    = state_q;

endmodule

// File: tb/tb_ramp_ctrl.sv
// tb_ramp_ctrl: directed vector table, corner sequences and random
// stimulus checked against a cycle-level reference of ramp_ctrl.
module tb_ramp_ctrl;

   localparam int STEP_CYC   = 4;
   localparam int FAULT_MAX  = 2;
   localparam int COOL_STEPS = 3;
   localparam int S_IDLE = 0;
   localparam int S_RAMP = 1;
   localparam int S_HOLD = 2;
   localparam int S_COOL = 3;
   localparam int S_LOCK = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic       ocd = 1'b0;
   logic [7:0] freq_tgt = '0;
   logic [7:0] pw_tgt = '0;
   logic [7:0] freq_par;
   logic [7:0] pw_par;
   logic       run;
   logic       fault;
   logic [2:0] state;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   ramp_ctrl #(
      .CLK_MHZ(4),
      .STEP_US(1),
      .PAR_MAX_VAL(255),
      .FAULT_MAX(FAULT_MAX),
      .COOL_STEPS(COOL_STEPS)
   ) dut (
      .clk(clk),
      .rst(rst),
      .en(en),
      .freq_tgt(freq_tgt),
      .pw_tgt(pw_tgt),
      .ocd(ocd),
      .freq_par(freq_par),
      .pw_par(pw_par),
      .run(run),
      .fault(fault),
      .state(state)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit en;
      int ft;
      int pt;
      bit ocd;
      int n;
      int st;
      int pw;
      int fr;
      int rn;
      int fl;
   } vec_t;

   vec_t vt[$];

   // reference: mode, outputs, trips, cycles since last RAMP/COOL entry
   int m_state, m_pw, m_fr, m_run, m_flt, m_fcnt, m_age;
   bit m_ocd_prev;

   function automatic int sgn(int x);
      return (x > 0) ? 1 : ((x < 0) ? -1 : 0);
   endfunction

   function automatic void model_reset();
      m_state = S_IDLE;
      m_pw = 0;
      m_fr = 0;
      m_run = 0;
      m_flt = 0;
      m_fcnt = 0;
      m_age = 0;
      m_ocd_prev = 1'b0;
   endfunction

   function automatic void model_edge();
      bit trip = ocd && !m_ocd_prev;
      bit step = ((m_age + 1) % STEP_CYC) == 0;
      int ft = int'(freq_tgt);
      int pt = int'(pw_tgt);
      int ns = m_state;
      bit restart = 1'b0;
      m_ocd_prev = ocd;
      case (m_state)
         S_IDLE: begin
            m_pw = 0;
            m_fr = ft;
            m_fcnt = 0;
            if (en) begin
               ns = S_RAMP;
               restart = 1'b1;
            end
         end
         S_RAMP, S_HOLD: begin
            if (trip) begin
               m_pw = 0;
               if (m_fcnt < FAULT_MAX) m_fcnt++;
               ns = (m_fcnt == FAULT_MAX) ? S_LOCK : S_COOL;
               restart = 1'b1;
            end else if (!en) begin
               m_pw = 0;
               ns = S_IDLE;
            end else if (m_state == S_RAMP) begin
               if (m_pw == pt && m_fr == ft) begin
                  ns = S_HOLD;
               end else if (step) begin
                  m_pw += sgn(pt - m_pw);
                  m_fr += sgn(ft - m_fr);
               end
            end else if (m_pw != pt || m_fr != ft) begin
               ns = S_RAMP;
               restart = 1'b1;
            end
         end
         S_COOL: begin
            if (m_age + 1 == COOL_STEPS * STEP_CYC) begin
               ns = en ? S_RAMP : S_IDLE;
               restart = 1'b1;
            end
         end
         S_LOCK: begin
            if (!en) begin
               m_fcnt = 0;
               ns = S_IDLE;
            end
         end
         default: ns = S_IDLE;
      endcase
      m_age = restart ? 0 : m_age + 1;
      m_state = ns;
      m_run = (ns == S_RAMP || ns == S_HOLD) ? 1 : 0;
      m_flt = (ns == S_LOCK) ? 1 : 0;
   endfunction

   task automatic check(string nm, int st, int pw, int fr, int rn, int fl);
      n_tests++;
      if ({state, pw_par, freq_par, run, fault} !==
          {3'(st), 8'(pw), 8'(fr), 1'(rn), 1'(fl)}) begin
         n_fail++;
         $display("FAIL %s: got st=%0d pw=%0d fr=%0d run=%0d flt=%0d want st=%0d pw=%0d fr=%0d run=%0d flt=%0d",
                  nm, state, pw_par, freq_par, run, fault, st, pw, fr, rn, fl);
      end
   endtask

   task automatic tick_clk();
      @(posedge clk);
      if (rst) model_reset();
      else model_edge();
      #1;
      cyc++;
      check($sformatf("model@%0d", cyc), m_state, m_pw, m_fr, m_run, m_flt);
   endtask

   function automatic void add(bit e, int ft, int pt, bit o, int n,
                               int st, int pw, int fr, int rn, int fl);
      vec_t v;
      v.en = e; v.ft = ft; v.pt = pt; v.ocd = o; v.n = n;
      v.st = st; v.pw = pw; v.fr = fr; v.rn = rn; v.fl = fl;
      vt.push_back(v);
   endfunction

   initial begin
      add(0, 10, 5, 0, 1, S_IDLE, 0, 10, 0, 0);
      add(1, 10, 5, 0, 1, S_RAMP, 0, 10, 1, 0);
      add(1, 10, 5, 0, 3, S_RAMP, 0, 10, 1, 0);
      add(1, 10, 5, 0, 1, S_RAMP, 1, 10, 1, 0);
      add(1, 10, 5, 0, 4, S_RAMP, 2, 10, 1, 0);
      add(1, 10, 5, 0, 4, S_RAMP, 3, 10, 1, 0);
      add(1, 10, 5, 0, 4, S_RAMP, 4, 10, 1, 0);
      add(1, 10, 5, 0, 4, S_RAMP, 5, 10, 1, 0);
      add(1, 10, 5, 0, 1, S_HOLD, 5, 10, 1, 0);
      add(1, 10, 5, 0, 5, S_HOLD, 5, 10, 1, 0);
      add(1, 10, 3, 0, 1, S_RAMP, 5, 10, 1, 0);
      add(1, 10, 3, 0, 4, S_RAMP, 4, 10, 1, 0);
      add(1, 10, 3, 0, 4, S_RAMP, 3, 10, 1, 0);
      add(1, 10, 3, 0, 1, S_HOLD, 3, 10, 1, 0);
      add(1, 10, 3, 1, 1, S_COOL, 0, 10, 0, 0);
      add(1, 10, 3, 0, 5, S_COOL, 0, 10, 0, 0);
      add(1, 10, 3, 1, 1, S_COOL, 0, 10, 0, 0);
      add(1, 10, 3, 0, 5, S_COOL, 0, 10, 0, 0);
      add(1, 10, 3, 0, 1, S_RAMP, 0, 10, 1, 0);
      add(1, 10, 3, 0, 4, S_RAMP, 1, 10, 1, 0);
      add(1, 10, 3, 0, 4, S_RAMP, 2, 10, 1, 0);
      add(1, 10, 3, 0, 4, S_RAMP, 3, 10, 1, 0);
      add(1, 10, 3, 0, 1, S_HOLD, 3, 10, 1, 0);
      add(1, 10, 3, 1, 1, S_LOCK, 0, 10, 0, 1);
      add(1, 10, 3, 0, 6, S_LOCK, 0, 10, 0, 1);
      add(0, 10, 3, 0, 1, S_IDLE, 0, 10, 0, 0);
      add(1, 10, 3, 0, 1, S_RAMP, 0, 10, 1, 0);
      add(1, 10, 3, 1, 1, S_COOL, 0, 10, 0, 0);
      add(0, 10, 3, 0, 12, S_IDLE, 0, 10, 0, 0);
      add(1, 10, 5, 0, 9, S_RAMP, 2, 10, 1, 0);
      add(0, 10, 5, 0, 1, S_IDLE, 0, 10, 0, 0);
      add(1, 10, 5, 0, 2, S_RAMP, 0, 10, 1, 0);
      add(0, 10, 5, 1, 1, S_COOL, 0, 10, 0, 0);
      add(0, 10, 5, 0, 12, S_IDLE, 0, 10, 0, 0);
      add(1, 10, 0, 0, 1, S_RAMP, 0, 10, 1, 0);
      add(1, 10, 0, 0, 1, S_HOLD, 0, 10, 1, 0);
      add(1, 10, 255, 0, 1, S_RAMP, 0, 10, 1, 0);
      add(1, 10, 255, 0, 1020, S_RAMP, 255, 10, 1, 0);
      add(1, 10, 255, 0, 1, S_HOLD, 255, 10, 1, 0);
      add(1, 10, 255, 0, 8, S_HOLD, 255, 10, 1, 0);
      add(1, 12, 255, 0, 1, S_RAMP, 255, 10, 1, 0);
      add(1, 12, 255, 0, 4, S_RAMP, 255, 11, 1, 0);
      add(1, 12, 255, 0, 4, S_RAMP, 255, 12, 1, 0);
      add(1, 12, 255, 0, 1, S_HOLD, 255, 12, 1, 0);
      add(1, 11, 255, 0, 1, S_RAMP, 255, 12, 1, 0);
      add(1, 11, 255, 0, 4, S_RAMP, 255, 11, 1, 0);
      add(1, 11, 255, 0, 1, S_HOLD, 255, 11, 1, 0);
      add(0, 11, 255, 0, 1, S_IDLE, 0, 11, 0, 0);
      add(0, 200, 0, 0, 1, S_IDLE, 0, 200, 0, 0);

      model_reset();
      #1;
      check("reset_state", 0, 0, 0, 0, 0);
      tick_clk();
      tick_clk();
      rst = 1'b0;

      for (int i = 0; i < vt.size(); i++) begin
         en = vt[i].en;
         freq_tgt = 8'(vt[i].ft);
         pw_tgt = 8'(vt[i].pt);
         ocd = vt[i].ocd;
         for (int k = 0; k < vt[i].n; k++) tick_clk();
         check($sformatf("vec[%0d]", i), vt[i].st, vt[i].pw,
               vt[i].fr, vt[i].rn, vt[i].fl);
      end

      // async reset between edges mid-RAMP, then resume with en held
      en = 1'b1; ocd = 1'b0; freq_tgt = 8'd10; pw_tgt = 8'd5;
      repeat (9) tick_clk();
      check("pre_rst", S_RAMP, 2, 10, 1, 0);
      #2;
      rst = 1'b1;
      #1;
      check("async_rst", S_IDLE, 0, 0, 0, 0);
      model_reset();
      tick_clk();
      rst = 1'b0;
      tick_clk();
      check("rst_resume", S_RAMP, 0, 10, 1, 0);

      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(0, 499) == 0);
         en = ($urandom_range(0, 19) != 0);
         ocd = ($urandom_range(0, 29) == 0);
         if ($urandom_range(0, 63) == 0) begin
            pw_tgt = ($urandom_range(0, 7) == 0) ?
                     8'($urandom_range(250, 255)) : 8'($urandom_range(0, 9));
         end
         if ($urandom_range(0, 63) == 0) begin
            freq_tgt = ($urandom_range(0, 7) == 0) ?
                       8'($urandom_range(250, 255)) : 8'($urandom_range(0, 9));
         end
         tick_clk();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ramp_ctrl.md
RAMP_CTRL -- requirements
Module: ramp_ctrl

Interface
REQ-001 SHALL have parameter CLK_MHZ, default 100, clock frequency in MHz.
REQ-002 SHALL have parameter STEP_US, default 1000, ramp step period in microseconds; STEP_CYC = CLK_MHZ*STEP_US cycles.
REQ-003 SHALL have parameter PAR_MAX_VAL, default 255, maximum value of every parameter bus; width W = $clog2(PAR_MAX_VAL+1).
REQ-004 SHALL have parameter FAULT_MAX, default 4, OCD trips before lockout.
REQ-005 SHALL have parameter COOL_STEPS, default 100, cooldown length in ramp steps.
REQ-006 SHALL have ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous active-high reset.
- en  in  1  run request, synchronous level.
- freq_tgt  in  W  target frequency parameter.
- pw_tgt  in  W  target pulse-width parameter.
- ocd  in  1  overcurrent detect, synchronous level.
- freq_par  out  W  frequency parameter to interrupter.
- pw_par  out  W  pulse-width parameter to interrupter.
- run  out  1  interrupter gate enable.
- fault  out  1  lockout indicator.
- state  out  3  current FSM state code.

Function
REQ-007 SHALL implement states IDLE=0, RAMP=1, HOLD=2, COOL=3, LOCK=4; all outputs registered.
REQ-008 SHALL generate a one-cycle tick every STEP_CYC cycles from a prescaler that restarts at 0 on every entry to RAMP or COOL.
REQ-009 IDLE: pw_par=0, run=0, freq_par<=freq_tgt each cycle, fault_cnt<=0; en=1 -> RAMP next cycle.
REQ-010 RAMP: run=1; on each tick pw_par and freq_par each move 1 toward their targets (unchanged if already equal); when pw_par==pw_tgt and freq_par==freq_tgt -> HOLD.
REQ-011 HOLD: run=1, outputs held; any target differing from its output -> RAMP (prescaler restarts).
REQ-012 Step arithmetic SHALL never wrap: increment only when below target, decrement only when above; results always in 0..PAR_MAX_VAL.
REQ-013 en=0 in RAMP or HOLD -> IDLE next cycle; pw_par=0 and run=0 in that same next cycle.
REQ-014 ocd rising edge (ocd=1 with previous-cycle ocd=0) in RAMP or HOLD SHALL set pw_par=0, run=0, fault_cnt+1 next cycle; -> LOCK if new fault_cnt==FAULT_MAX, else COOL.
REQ-015 COOL: run=0, pw_par=0; after COOL_STEPS ticks -> RAMP if en=1, else IDLE; ocd edges ignored.
REQ-016 LOCK: run=0, pw_par=0, fault=1; en=0 -> IDLE (fault=0, fault_cnt=0); otherwise stay.
REQ-017 Simultaneous ocd edge and en=0 SHALL take the ocd path (priority: ocd > en > tick).
REQ-018 fault_cnt SHALL be $clog2(FAULT_MAX+1) bits, saturating, cleared only in IDLE or by reset.
REQ-019 freq_par SHALL be frozen in COOL and LOCK.

Reset
REQ-020 rst=1 SHALL immediately force state=IDLE, pw_par=0, freq_par=0, run=0, fault=0, fault_cnt=0, prescaler=0, cooldown counter=0, ocd history=0.
REQ-021 Reset deassertion mid-operation SHALL resume from IDLE; if en=1, RAMP entry occurs on the first clock after deassertion.

Verification (CLK_MHZ=4, STEP_US=1 -> STEP_CYC=4, FAULT_MAX=2, COOL_STEPS=3)
REQ-022 Soft start: freq_tgt=10, pw_tgt=5, en=1 from IDLE -> pw_par 1,2,3,4,5 at 4-cycle spacing; HOLD after 5 ticks; run=1 throughout.
REQ-023 Retarget: in HOLD, pw_tgt 5->3 -> RAMP; pw_par 4,3 on next two ticks; HOLD; freq_par stays 10.
REQ-024 Single trip: ocd pulse in HOLD -> next cycle pw_par=0, run=0, state=COOL; after 12 cycles -> RAMP; ramp from 0.
REQ-025 Lockout: second ocd edge without passing IDLE -> LOCK, fault=1; en held 1 keeps LOCK; en=0 -> IDLE, fault=0.
REQ-026 Boundary: pw_tgt=0 with en=1 -> RAMP then HOLD on the first evaluation with pw_par=0, no underflow; pw_tgt=255 ramps to 255 without wrap.
REQ-027 Async reset: rst asserted between clock edges mid-RAMP -> all outputs 0 before next edge; state=IDLE.
